efuse_ctrl_sched: RTL and testbench

Sequencer and request arbiter in front of `efuse_rw_timing`. It runs the autoload of all 256 eFuse bits after reset into a shadow register and drives the timing core's start, select, mode and data inputs. After autoload it serves one software request at a time, either a segment read or a segment program with optional read-back verify. It is the only block allowed to drive the timing core's control inputs.

---
 rtl/efuse_pkg.sv | 26 ++
 rtl/efuse_ctrl_sched.sv | 163 ++++++++++++++++
 tb/tb_efuse_ctrl_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/efuse_pkg.sv
// Shared eFuse definitions: array size, default segment width, sequencer
// states and operation encoding.
package efuse_pkg;

  localparam int unsigned EFUSE_BITS = 256;
  localparam int unsigned SEG_W_DEF  = 64;

  typedef enum logic [3:0] {
    AL_START,
    AL_WAIT,
    IDLE,
    RD_START,
    RD_WAIT,
    WR_START,
    WR_WAIT,
    VF_START,
    VF_WAIT
  } state_t;

  // Value driven onto the timing core's rg_efuse_mode.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/efuse_ctrl_sched.sv
// Sequencer/arbiter in front of efuse_rw_timing: autoloads all segments into
// a shadow image after reset, then serves single segment read/program requests.
module efuse_ctrl_sched
  import efuse_pkg::*;
#(
  parameter int unsigned SEG_W  = SEG_W_DEF,
  parameter bit          VERIFY = 1'b1,
  localparam int unsigned SEG_N = EFUSE_BITS / SEG_W,
  localparam int unsigned SEL_W = (SEG_N > 1) ? $clog2(SEG_N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [SEL_W-1:0]      req_sel,
  input  logic [SEG_W-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [SEG_W-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic [EFUSE_BITS-1:0] shadow,
  output logic                  autoload_done,
  output logic                  core_read_start,
  output logic                  core_write_start,
  output logic [SEL_W-1:0]      core_sel,
  output logic                  core_mode,
  output logic                  core_autoload,
  output logic [SEG_W-1:0]      core_wdata,
  input  logic [SEG_W-1:0]      core_rdata,
  input  logic                  core_read_done,
  input  logic                  core_write_done
);

  state_t           state, state_d;
  logic [SEL_W-1:0] seg_cnt;

  logic             accept, reload_go, seg_inc, al_finish;
  logic             shadow_we, rsp_set, rsp_err_d;
  logic [SEL_W-1:0] shadow_idx;
  logic [SEG_W-1:0] shadow_val, cur_seg;

  assign cur_seg = shadow[core_sel*SEG_W +: SEG_W];

  // Decoded outputs are gated by rst so the reset state (AL_START) shows no
  // start pulse until reset is released.
  assign req_ready        = !rst && (state == IDLE) && autoload_done && !reload;
  assign core_read_start  = !rst && (state == AL_START || state == RD_START || state == VF_START);
  assign core_write_start = !rst && (state == WR_START);
  assign core_autoload    = !rst && (state == AL_START || state == AL_WAIT);

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    reload_go  = 1'b0;
    seg_inc    = 1'b0;
    al_finish  = 1'b0;
    shadow_we  = 1'b0;
    shadow_idx = core_sel;
    shadow_val = core_rdata;
    rsp_set    = 1'b0;
    rsp_err_d  = 1'b0;
    case (state)
      AL_START: state_d = AL_WAIT;
      AL_WAIT: begin
        if (core_read_done) begin
          shadow_we  = 1'b1;
          shadow_idx = seg_cnt;
          if (seg_cnt == SEL_W'(SEG_N - 1)) begin
            al_finish = 1'b1;
            state_d   = IDLE;
          end else begin
            seg_inc = 1'b1;
            state_d = AL_START;
          end
        end
      end
      IDLE: begin
        if (reload) begin
          reload_go = 1'b1;
          state_d   = AL_START;
        end else if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_d = req_write ? WR_START : RD_START;
        end
      end
      RD_START: state_d = RD_WAIT;
      RD_WAIT: begin
        if (core_read_done) begin
          shadow_we = 1'b1;
          rsp_set   = 1'b1;
          state_d   = IDLE;
        end
      end
      WR_START: state_d = WR_WAIT;
      WR_WAIT: begin
        if (core_write_done) begin
          if (VERIFY) begin
            state_d = VF_START;
          end else begin
            shadow_we  = 1'b1;
            shadow_val = cur_seg | core_wdata;
            rsp_set    = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      VF_START: state_d = VF_WAIT;
      VF_WAIT: begin
        if (core_read_done) begin
          shadow_we = 1'b1;
          rsp_set   = 1'b1;
          rsp_err_d = ((core_rdata & core_wdata) != core_wdata);
          state_d   = IDLE;
        end
      end
      default: state_d = AL_START;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= AL_START;
      seg_cnt       <= '0;
      core_sel      <= '0;
      core_wdata    <= '0;
      core_mode     <= 1'b0;
      shadow        <= '0;
      autoload_done <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      state     <= state_d;
      rsp_valid <= rsp_set;
      if (rsp_set) begin
        rsp_rdata <= shadow_val;
        rsp_err   <= rsp_err_d;
      end
      if (shadow_we) shadow[shadow_idx*SEG_W +: SEG_W] <= shadow_val;
      if (al_finish) autoload_done <= 1'b1;
      if (reload_go) begin
        autoload_done <= 1'b0;
        seg_cnt       <= '0;
        core_sel      <= '0;
      end
      if (seg_inc) begin
        seg_cnt  <= seg_cnt + 1'b1;
        core_sel <= seg_cnt + 1'b1;
      end
      if (accept) begin
        core_sel   <= req_sel;
        core_wdata <= req_wdata;
      end
      // Every *_START state is entered for exactly one cycle, so this only
      // fires on the entering edge and the mode stays put for the operation.
      if (state_d == AL_START || state_d == RD_START ||
          state_d == WR_START || state_d == VF_START)
        core_mode <= (state_d == WR_START) ? OP_WRITE : OP_READ;
    end
  end

endmodule

// File: tb/tb_efuse_ctrl_sched.sv
// Directed bench for efuse_ctrl_sched with a behavioural eFuse timing core.
module tb_efuse_ctrl_sched;
  import efuse_pkg::*;

  localparam logic [63:0] SEG0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SEG1 = 64'h1111_2222_3333_4400;
  localparam logic [63:0] SEG2 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] SEG3 = 64'hA5A5_5A5A_0F0F_F0F0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         reload = 1'b0, req_valid = 1'b0, req_write = 1'b0;
  logic [1:0]   req_sel = '0;
  logic [63:0]  req_wdata = '0;
  logic         req_ready, rsp_valid, rsp_err, autoload_done;
  logic [63:0]  rsp_rdata, core_wdata;
  logic [255:0] shadow;
  logic         core_read_start, core_write_start, core_mode, core_autoload;
  logic [1:0]   core_sel;
  logic [63:0]  core_rdata = '0;
  logic         core_read_done = 1'b0, core_write_done = 1'b0;

  efuse_ctrl_sched #(.SEG_W(64), .VERIFY(1'b1)) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sel(req_sel), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .shadow(shadow), .autoload_done(autoload_done),
    .core_read_start(core_read_start), .core_write_start(core_write_start),
    .core_sel(core_sel), .core_mode(core_mode), .core_autoload(core_autoload),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_read_done(core_read_done), .core_write_done(core_write_done)
  );

  always #5 clk = ~clk;

  // Behavioural timing core: sticky done flags cleared by the start pulse.
  logic         fuse_load = 1'b1;
  logic [255:0] fuse;
  logic [63:0]  drop_mask = '0;
  int           rd_cnt = 0, wr_cnt = 0;
  logic [1:0]   rd_seg = '0, wr_seg = '0;
  logic [63:0]  wr_val = '0;

  always @(posedge clk) begin
    if (fuse_load) fuse <= {SEG3, SEG2, SEG1, SEG0};
    if (rst) begin
      core_read_done  <= 1'b0;
      core_write_done <= 1'b0;
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      if (core_read_start) begin
        core_read_done <= 1'b0;
        rd_cnt <= 3;
        rd_seg <= core_sel;
      end else if (rd_cnt == 1) begin
        rd_cnt <= 0;
        core_read_done <= 1'b1;
        core_rdata <= fuse[rd_seg*64 +: 64];
      end else if (rd_cnt > 1) begin
        rd_cnt <= rd_cnt - 1;
      end
      if (core_write_start) begin
        core_write_done <= 1'b0;
        wr_seg <= core_sel;
        wr_val <= core_wdata & ~drop_mask;
        wr_cnt <= (core_wdata == '0) ? 1 : 4;
      end else if (wr_cnt == 1) begin
        wr_cnt <= 0;
        core_write_done <= 1'b1;
        fuse[wr_seg*64 +: 64] <= fuse[wr_seg*64 +: 64] | wr_val;
      end else if (wr_cnt > 1) begin
        wr_cnt <= wr_cnt - 1;
      end
    end
  end

  int n_wstart = 0, n_rsp = 0;
  always @(negedge clk) begin
    if (core_write_start) n_wstart <= n_wstart + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] outs_flat();
    return {118'd0, core_read_start, core_write_start, core_sel, core_mode, core_autoload,
            core_wdata, rsp_valid, rsp_rdata, rsp_err, autoload_done, req_ready};
  endfunction

  // Called at a negedge; follows the autoload through completion.
  task automatic run_autoload(input logic [255:0] exp_shadow, input string tag);
    int n = 0;
    for (int c = 0; c < 400 && !autoload_done; c++) begin
      if (core_read_start) begin
        chk({tag, "_al_sel"}, core_sel, n);
        chk({tag, "_al_flag"}, core_autoload, 1'b1);
        chk({tag, "_al_mode"}, core_mode, 1'b0);
        n++;
      end
      @(negedge clk);
    end
    chk({tag, "_al_done"}, autoload_done, 1'b1);
    chk({tag, "_al_starts"}, n, 4);
    chk({tag, "_al_shadow"}, shadow, exp_shadow);
  endtask

  typedef struct {
    logic        write;
    logic [1:0]  sel;
    logic [63:0] wdata;
    logic [63:0] drop;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic do_req(input vec_t v, input int idx);
    string t = $sformatf("v%0d", idx);
    bit saw = 0, saw_vf = 0;
    chk({t, "_ready"}, req_ready, 1'b1);
    drop_mask = v.drop;
    req_valid = 1'b1; req_write = v.write; req_sel = v.sel; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    chk({t, "_start"}, {core_read_start, core_write_start}, v.write ? 2'b01 : 2'b10);
    chk({t, "_mode"}, core_mode, v.write);
    chk({t, "_sel"}, core_sel, v.sel);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (v.write && core_read_start) begin
        saw_vf = 1;
        chk({t, "_vf_mode"}, core_mode, 1'b0);
        chk({t, "_vf_sel"}, core_sel, v.sel);
      end
      if (rsp_valid) begin
        saw = 1;
        break;
      end
    end
    chk({t, "_rsp_seen"}, saw, 1'b1);
    if (v.write) chk({t, "_vf_seen"}, saw_vf, 1'b1);
    chk({t, "_rdata"}, rsp_rdata, v.exp_rdata);
    chk({t, "_err"}, rsp_err, v.exp_err);
    chk({t, "_ready_at_rsp"}, req_ready, 1'b1);
    chk({t, "_shadow"}, shadow[v.sel*64 +: 64], v.exp_rdata);
    @(negedge clk);
    chk({t, "_rsp_pulse"}, rsp_valid, 1'b0);
    drop_mask = '0;
  endtask

  logic [255:0] img;
  int wstart0, rsp0;

  initial begin
    vecs[0] = '{1'b0, 2'd2, 64'h0, 64'h0, SEG2, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 64'h0000_0000_0000_00F0, 64'h0, 64'h1111_2222_3333_44F0, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 64'h0000_0000_0000_0022, 64'h0000_0000_0000_0020,
                64'hDEAD_BEEF_CAFE_F00F, 1'b1};
    vecs[3] = '{1'b1, 2'd3, 64'h0, 64'h0, SEG3, 1'b0};
    vecs[4] = '{1'b0, 2'd1, 64'h0, 64'h0, 64'h1111_2222_3333_44F0, 1'b0};
    vecs[5] = '{1'b0, 2'd2, 64'h0, 64'h0, 64'hDEAD_BEEF_CAFE_F00F, 1'b0};

    #1;
    chk("reset_outs", outs_flat(), '0);
    chk("reset_shadow", shadow, '0);
    repeat (2) @(posedge clk);
    #1 fuse_load = 1'b0; rst = 1'b0;
    @(negedge clk);
    run_autoload({SEG3, SEG2, SEG1, SEG0}, "boot");

    foreach (vecs[i]) do_req(vecs[i], i);

    // reload wins over a simultaneous request
    img = {SEG3, 64'hDEAD_BEEF_CAFE_F00F, 64'h1111_2222_3333_44F0, SEG0};
    wstart0 = n_wstart;
    reload = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_sel = 2'd0; req_wdata = 64'h10;
    #1 chk("reload_ready_low", req_ready, 1'b0);
    @(negedge clk);
    reload = 1'b0; req_valid = 1'b0;
    chk("reload_done_cleared", autoload_done, 1'b0);
    run_autoload(img, "reload");
    chk("reload_no_write", n_wstart, wstart0);

    // rst during WR_WAIT aborts the program
    req_valid = 1'b1; req_write = 1'b1; req_sel = 2'd0; req_wdata = 64'h10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_wstart", core_write_start, 1'b1);
    @(negedge clk);
    rsp0 = n_rsp;
    rst = 1'b1;
    #1;
    chk("abort_outs", outs_flat(), '0);
    chk("abort_shadow", shadow, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_autoload(img, "abort");
    repeat (5) @(negedge clk);
    chk("abort_no_rsp", n_rsp, rsp0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
